asym_ram_burst_reader: RTL and testbench
========================================

ASYM_RAM_BURST_READER -- requirements
Module: asym_ram_burst_reader

Interface
REQ-001 Parameter AWB, default 8, read-port address width of the attached wide-read RAM.
REQ-002 Parameter DWB, default 16, read-port data width of the attached RAM.
REQ-003 Parameter FIFO_DEPTH, default 4, output buffer depth; power of two, minimum 4.
REQ-004 clk  input  1  single clock for all logic; the RAM read port (clkb) SHALL be driven by the same clock.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle burst request; sampled only in IDLE.
REQ-007 base_addr  input  AWB  first RAM word address, sampled with start.
REQ-008 burst_len  input  AWB+1  number of words, 1..2**AWB, sampled with start.
REQ-009 reb  output  1  RAM read enable.
REQ-010 addrb  output  AWB  RAM read address.
REQ-011 doutb  input  DWB  RAM read data.
REQ-012 m_data  output  DWB  stream data.
REQ-013 m_valid  output  1  stream valid.
REQ-014 m_ready  input  1  stream ready.
REQ-015 m_last  output  1  marks the final word of a burst.
REQ-016 busy  output  1  high from start acceptance until done.
REQ-017 done  output  1  one-cycle pulse at burst completion.

Function
REQ-018 RAM timing: reb/addrb driven in cycle t yield valid doutb in cycle t+2; the block SHALL capture doutb exactly 2 cycles after each issued read, using a 2-stage valid/last tag pipeline.
REQ-019 FSM states IDLE, RUN, DRAIN; reset state IDLE.
REQ-020 IDLE -> RUN on start with burst_len != 0: latch base_addr into read pointer, burst_len into remaining counter, assert busy next cycle.
REQ-021 start with burst_len == 0 SHALL be ignored (no busy, no done); start outside IDLE SHALL be ignored.
REQ-022 RUN: issue one read (reb=1, addrb=read pointer) per cycle while credit is available; credit = FIFO_DEPTH minus (FIFO occupancy + reads in flight) > 0.
REQ-023 Each issued read increments the read pointer modulo 2**AWB (wrap from 2**AWB-1 to 0) and decrements the remaining counter.
REQ-024 RUN -> DRAIN in the cycle after the final read is issued; reb SHALL be 0 whenever no read is issued, addrb then don't-care.
REQ-025 Captured words enter the FIFO in issue order; m_last SHALL be set on the word from the final read only.
REQ-026 m_valid = FIFO not empty; m_data/m_last from FIFO head; a word leaves on m_valid && m_ready; m_data/m_last SHALL stay stable while m_valid && !m_ready.
REQ-027 Simultaneous FIFO push and pop SHALL be supported in one cycle; credit accounting SHALL guarantee the FIFO never overflows.
REQ-028 Full throughput: with m_ready held high, one word per cycle after a 3-cycle initial latency (start to first m_valid).
REQ-029 DRAIN -> IDLE when the m_last word is accepted; done pulses high that same cycle... registered: done=1 in the cycle following acceptance, busy falls in that same following cycle.
REQ-030 A start coinciding with the done cycle SHALL be accepted (state is IDLE then).

Reset
REQ-031 On rst: state IDLE, reb=0, addrb=0, m_valid=0, m_data=0, m_last=0, busy=0, done=0, FIFO empty, counters and tag pipeline cleared.
REQ-032 Reset mid-burst SHALL discard in-flight reads: RAM data arriving 1-2 cycles after reset deasserts SHALL NOT enter the FIFO.

Verification
REQ-033 RAM preloaded word[n]=n; start, base_addr=0x10, burst_len=4, m_ready=1 -> m_data 0x10,0x11,0x12,0x13 on consecutive cycles, first m_valid 3 cycles after start, m_last on 0x13, done 1 cycle after.
REQ-034 base_addr=0xFE, burst_len=4 -> addrb sequence 0xFE,0xFF,0x00,0x01; m_data 0xFE,0xFF,0x00,0x01.
REQ-035 burst_len=16, m_ready=0 for 20 cycles then 1 -> exactly 4 reads issued before stall, no data lost or duplicated, 16 words in order, m_data stable during stall.
REQ-036 m_ready toggling 1,0,1,0 over burst_len=8 -> all 8 words delivered in order, FIFO occupancy never exceeds 4.
REQ-037 rst asserted 1 cycle after third read of burst_len=10 -> all outputs 0 next cycle, m_valid stays 0 until a new start; start with burst_len=0 -> busy stays 0.

Source files
------------

// File: rtl/asym_ram_burst_reader.sv
// Burst reader for a 2-cycle-latency RAM read port: issues credit-limited reads,
// realigns returning data with a tag pipeline and buffers it behind a ready/valid stream.
module asym_ram_burst_reader #(
  parameter int AWB        = 8,
  parameter int DWB        = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [AWB-1:0] base_addr,
  input  logic [AWB:0]   burst_len,
  output logic           reb,
  output logic [AWB-1:0] addrb,
  input  logic [DWB-1:0] doutb,
  output logic [DWB-1:0] m_data,
  output logic           m_valid,
  input  logic           m_ready,
  output logic           m_last,
  output logic           busy,
  output logic           done
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t         state, state_nxt;
  logic [AWB-1:0] rd_ptr, rd_ptr_nxt;
  logic [AWB:0]   remain, remain_nxt;
  logic           issue, issue_last;
  logic [AWB-1:0] issue_addr;

  logic           vld_p0, last_p0;
  logic           vld_p1, last_p1;

  logic [DWB-1:0]        fifo_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last;
  logic [PW-1:0]         wr_idx, rd_idx;
  logic [CW-1:0]         count;
  logic [CW-1:0]         in_flight;
  logic                  credit_ok;
  logic                  push, pop;
  logic                  done_r;

  // Credit counts reads still in the tag pipeline so the FIFO can never overflow.
  assign in_flight = CW'(vld_p0) + CW'(vld_p1);
  assign credit_ok = (count + in_flight) < CW'(FIFO_DEPTH);

  assign push = vld_p1;
  assign pop  = m_valid && m_ready;

  // The first read is issued in the accepting IDLE cycle to reach a 3-cycle latency.
  always_comb begin
    state_nxt  = state;
    rd_ptr_nxt = rd_ptr;
    remain_nxt = remain;
    issue      = 1'b0;
    issue_last = 1'b0;
    issue_addr = rd_ptr;
    unique case (state)
      IDLE: begin
        if (start && (burst_len != '0)) begin
          issue      = 1'b1;
          issue_addr = base_addr;
          issue_last = (burst_len == (AWB+1)'(1));
          rd_ptr_nxt = base_addr + 1'b1;
          remain_nxt = burst_len - 1'b1;
          state_nxt  = issue_last ? DRAIN : RUN;
        end
      end
      RUN: begin
        if (credit_ok) begin
          issue      = 1'b1;
          issue_last = (remain == (AWB+1)'(1));
          rd_ptr_nxt = rd_ptr + 1'b1;
          remain_nxt = remain - 1'b1;
          if (issue_last) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && m_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) issue = 1'b0;
  end

  assign reb   = issue;
  assign addrb = issue ? issue_addr : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rd_ptr  <= '0;
      remain  <= '0;
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      wr_idx  <= '0;
      rd_idx  <= '0;
      count   <= '0;
      done_r  <= 1'b0;
    end else begin
      state   <= state_nxt;
      rd_ptr  <= rd_ptr_nxt;
      remain  <= remain_nxt;
      // p0: read issued last cycle; p1: RAM data presented this cycle
      vld_p0  <= issue;
      last_p0 <= issue && issue_last;
      vld_p1  <= vld_p0;
      last_p1 <= last_p0;
      if (push) wr_idx <= wr_idx + 1'b1;
      if (pop)  rd_idx <= rd_idx + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      done_r  <= (state == DRAIN) && pop && m_last;
    end
  end

  // FIFO storage holds data only; validity comes from count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_idx]  <= doutb;
      fifo_last[wr_idx] <= last_p1;
    end
  end

  assign m_valid = (count != '0);
  assign m_data  = m_valid ? fifo_mem[rd_idx] : '0;
  assign m_last  = m_valid && fifo_last[rd_idx];
  assign busy    = (state != IDLE);
  assign done    = done_r;

endmodule

// File: tb/tb_asym_ram_burst_reader.sv
// Directed bench for asym_ram_burst_reader with a 2-cycle RAM model holding word[n]=n.
module tb_asym_ram_burst_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  base_addr;
  logic [8:0]  burst_len;
  logic        reb;
  logic [7:0]  addrb;
  logic [15:0] doutb;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic        busy;
  logic        done;

  logic [15:0] ram_q1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0]  base;
    logic [8:0]  len;
    int          mode;      // 0: ready high, 1: toggle 1,0,..., 2: low for 20 cycles
    logic [15:0] exp_first;
    logic [15:0] exp_final;
  } vec_t;

  vec_t vecs [6];

  asym_ram_burst_reader #(.AWB(8), .DWB(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .burst_len(burst_len),
    .reb(reb), .addrb(addrb), .doutb(doutb), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reb) ram_q1 <= {8'h00, addrb};
    doutb <= ram_q1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [7:0] b, input logic [8:0] l, input logic r);
    @(negedge clk);
    start     = s;
    base_addr = b;
    burst_len = l;
    m_ready   = r;
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_reb"}, reb, 0);
    chk({tag, "_addrb"}, addrb, 0);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_data"}, m_data, 0);
    chk({tag, "_m_last"}, m_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic run_burst(input vec_t v);
    int cyc = 0;
    int nread = 0;
    int nacc = 0;
    int last_acc = -1;
    int stall_reads = 0;
    logic held_v = 1'b0;
    logic [15:0] held = '0;
    logic done_seen = 1'b0;
    logic rdy;
    logic [7:0] e;
    while (cyc < 200 && !done_seen) begin
      case (v.mode)
        1:       rdy = (cyc % 2 == 0);
        2:       rdy = (cyc >= 20);
        default: rdy = 1'b1;
      endcase
      // second start at cycle 2 must be ignored
      drive((cyc == 0) || (cyc == 2), (cyc == 0) ? v.base : 8'h55,
            (cyc == 0) ? v.len : 9'd3, rdy);
      if (last_acc >= 0 && cyc == last_acc + 1) begin
        chk("done_pulse", done, 1);
        chk("busy_after_done", busy, 0);
        done_seen = 1'b1;
      end else begin
        chk("done_low", done, 0);
        chk("busy", busy, (cyc > 0));
        if (reb) begin
          e = v.base + 8'(nread);
          chk("addrb", addrb, e);
          nread++;
          if (v.mode == 2 && cyc < 20) stall_reads++;
        end
        chk("occupancy", ((nread - nacc) <= 4), 1);
        if (held_v) begin
          chk("stall_valid", m_valid, 1);
          chk("stall_data", m_data, held);
        end
        held_v = 1'b0;
        if (m_valid) begin
          if (m_ready) begin
            e = v.base + 8'(nacc);
            chk("m_data", m_data, {8'h00, e});
            chk("m_last", m_last, (nacc == int'(v.len) - 1));
            if (nacc == 0) chk("first_word", m_data, v.exp_first);
            if (nacc == int'(v.len) - 1) begin
              chk("final_word", m_data, v.exp_final);
              last_acc = cyc;
            end
            if (v.mode == 0) chk("accept_cycle", cyc, 3 + nacc);
            nacc++;
          end else begin
            held_v = 1'b1;
            held   = m_data;
          end
        end
      end
      cyc++;
    end
    chk("done_seen", done_seen, 1);
    chk("words_delivered", nacc, int'(v.len));
    chk("reads_issued", nread, int'(v.len));
    if (v.mode == 2) chk("reads_before_stall", stall_reads, 4);
  endtask

  initial begin
    vecs[0] = '{base: 8'h10, len: 9'd4,  mode: 0, exp_first: 16'h0010, exp_final: 16'h0013};
    vecs[1] = '{base: 8'hFE, len: 9'd4,  mode: 0, exp_first: 16'h00FE, exp_final: 16'h0001};
    vecs[2] = '{base: 8'h00, len: 9'd16, mode: 2, exp_first: 16'h0000, exp_final: 16'h000F};
    vecs[3] = '{base: 8'h40, len: 9'd8,  mode: 1, exp_first: 16'h0040, exp_final: 16'h0047};
    vecs[4] = '{base: 8'h80, len: 9'd1,  mode: 0, exp_first: 16'h0080, exp_final: 16'h0080};
    vecs[5] = '{base: 8'hF0, len: 9'd20, mode: 1, exp_first: 16'h00F0, exp_final: 16'h0003};

    rst = 1'b1;
    start = 1'b0; base_addr = '0; burst_len = '0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    drive(0, 8'h00, 9'd0, 0);
    check_all_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_burst(vecs[i]);

    // start accepted in the done cycle
    drive(1, 8'h30, 9'd2, 1);
    repeat (4) drive(0, 8'h00, 9'd0, 1);
    drive(1, 8'h20, 9'd1, 1);
    chk("b2b_done", done, 1);
    chk("b2b_reb", reb, 1);
    chk("b2b_addrb", addrb, 8'h20);
    drive(0, 8'h00, 9'd0, 1);
    chk("b2b_busy", busy, 1);
    repeat (2) drive(0, 8'h00, 9'd0, 1);
    chk("b2b_valid", m_valid, 1);
    chk("b2b_data", m_data, 16'h0020);
    chk("b2b_last", m_last, 1);
    drive(0, 8'h00, 9'd0, 1);
    chk("b2b_done2", done, 1);

    // reset one cycle after the third read of a 10-word burst
    drive(1, 8'h00, 9'd10, 1);
    drive(0, 8'h00, 9'd0, 1);
    drive(0, 8'h00, 9'd0, 1);
    chk("rst_third_read", reb, 1);
    @(negedge clk); rst = 1'b1; #1;
    @(negedge clk); rst = 1'b0; #1;
    check_all_zero("midrst");
    for (int k = 0; k < 8; k++) begin
      drive(0, 8'h00, 9'd0, 1);
      chk("midrst_no_valid", m_valid, 0);
    end

    // zero-length start is ignored
    drive(1, 8'h44, 9'd0, 1);
    chk("len0_reb", reb, 0);
    for (int k = 0; k < 4; k++) begin
      drive(0, 8'h00, 9'd0, 1);
      chk("len0_busy", busy, 0);
      chk("len0_done", done, 0);
      chk("len0_valid", m_valid, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
